// File: rtl/btb_predictor.sv
// Direct-mapped BTB with saturating direction counters; zero-latency lookup, update on posedge, no backpressure.
// Optional macro BTB_BYPASS_EN forwards a same-cycle update at the looked-up index to the fetch outputs.
module btb_predictor #(
   parameter int AWIDTH   = 32,
   parameter int ENTRIES  = 16,
   parameter int CTR_BITS = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [AWIDTH-1:0] PC_f,
   output logic              hit_f,
   output logic              pred_taken_f,
   output logic [AWIDTH-1:0] BrTarget,
   input  logic              Br_x,
   input  logic [AWIDTH-1:0] PC_x,
   input  logic              taken_x,
   input  logic [AWIDTH-1:0] alu_out,
   input  logic              flush
);

   localparam int IDX_W = $clog2(ENTRIES);
   localparam int TAG_W = AWIDTH - IDX_W - 2;
   localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
   localparam logic [CTR_BITS-1:0] CTR_WEAK = CTR_BITS'(2 ** (CTR_BITS - 1));

   logic [ENTRIES-1:0]  r_valid;
   logic [TAG_W-1:0]    r_tag    [ENTRIES];
   logic [AWIDTH-1:0]   r_target [ENTRIES];
   logic [CTR_BITS-1:0] r_ctr    [ENTRIES];

   logic [IDX_W-1:0]    w_idx_f, w_idx_x;
   logic [TAG_W-1:0]    w_tag_f, w_tag_x;
   logic [AWIDTH-1:0]   w_pc_f_inc;
   logic                w_hit_x;
   logic                w_upd_en;
   logic [CTR_BITS-1:0] w_cur_ctr;
   logic [CTR_BITS-1:0] w_upd_ctr;
   logic [AWIDTH-1:0]   w_upd_tgt;
   logic                w_lk_vld;
   logic [TAG_W-1:0]    w_lk_tag;
   logic [AWIDTH-1:0]   w_lk_tgt;
   logic [CTR_BITS-1:0] w_lk_ctr;
   logic                w_unused_pc_lsb;

   assign w_idx_f    = PC_f[IDX_W+1:2];
   assign w_tag_f    = PC_f[AWIDTH-1:IDX_W+2];
   assign w_idx_x    = PC_x[IDX_W+1:2];
   assign w_tag_x    = PC_x[AWIDTH-1:IDX_W+2];
   assign w_pc_f_inc = PC_f + AWIDTH'(4);
   assign w_unused_pc_lsb = &{1'b0, PC_f[1:0], PC_x[1:0]};

   // Resolved-branch update: next value of the entry selected by PC_x.
   assign w_hit_x   = r_valid[w_idx_x] & (r_tag[w_idx_x] == w_tag_x);
   assign w_upd_en  = Br_x & ~flush & (w_hit_x | taken_x);
   assign w_cur_ctr = r_ctr[w_idx_x];
   assign w_upd_tgt = taken_x ? alu_out : r_target[w_idx_x];

   always_comb begin
      w_upd_ctr = CTR_WEAK;
      if (w_hit_x) begin
         if (taken_x)
            w_upd_ctr = (w_cur_ctr == CTR_MAX) ? w_cur_ctr : w_cur_ctr + 1'b1;
         else
            w_upd_ctr = (w_cur_ctr == '0) ? w_cur_ctr : w_cur_ctr - 1'b1;
      end
   end

   always_comb begin
      w_lk_vld = r_valid[w_idx_f];
      w_lk_tag = r_tag[w_idx_f];
      w_lk_tgt = r_target[w_idx_f];
      w_lk_ctr = r_ctr[w_idx_f];
`ifdef BTB_BYPASS_EN
      if (rst_n && w_upd_en && (w_idx_x == w_idx_f)) begin
         w_lk_vld = 1'b1;
         w_lk_tag = w_tag_x;
         w_lk_tgt = w_upd_tgt;
         w_lk_ctr = w_upd_ctr;
      end
`endif
   end

   // Tags of invalid entries may be X; the AND with valid keeps hit_f clean.
   assign hit_f        = w_lk_vld & (w_lk_tag == w_tag_f);
   assign pred_taken_f = hit_f & w_lk_ctr[CTR_BITS-1];
   assign BrTarget     = pred_taken_f ? w_lk_tgt : w_pc_f_inc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= '0;
         for (int i = 0; i < ENTRIES; i++)
            r_ctr[i] <= '0;
      end else if (flush) begin
         r_valid <= '0;
      end else if (w_upd_en) begin
         r_valid[w_idx_x] <= 1'b1;
         r_ctr[w_idx_x]   <= w_upd_ctr;
      end
   end

   // Tag/target payload needs no reset; validity is carried by r_valid alone.
   always_ff @(posedge clk) begin
      if (w_upd_en) begin
         r_tag[w_idx_x]    <= w_tag_x;
         r_target[w_idx_x] <= w_upd_tgt;
      end
   end

endmodule

// File: tb/tb_btb_predictor.sv
// Scoreboarded bench for btb_predictor: expected lookups queued at drive time, popped at sample time.
module tb_btb_predictor;

   typedef struct packed {
      logic        hit;
      logic        pred;
      logic [31:0] tgt;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] PC_f;
   logic        hit_f;
   logic        pred_taken_f;
   logic [31:0] BrTarget;
   logic        Br_x;
   logic [31:0] PC_x;
   logic        taken_x;
   logic [31:0] alu_out;
   logic        flush;

   exp_t sb_q[$];
   exp_t e;
   exp_t obs;
   int   checks = 0;
   int   errors = 0;

   btb_predictor dut (
      .clk(clk), .rst_n(rst_n), .PC_f(PC_f), .hit_f(hit_f),
      .pred_taken_f(pred_taken_f), .BrTarget(BrTarget), .Br_x(Br_x),
      .PC_x(PC_x), .taken_x(taken_x), .alu_out(alu_out), .flush(flush)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, time=%0t limit=200000", $time);
      $fatal(1);
   end

   task automatic push_exp(input logic h, input logic p, input logic [31:0] t);
      exp_t x;
      x.hit = h; x.pred = p; x.tgt = t;
      sb_q.push_back(x);
   endtask

   // Drives one update at the current negedge, lets it take effect, returns at the next negedge.
   task automatic do_update(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
      Br_x = 1'b1; PC_x = pc; taken_x = tk; alu_out = tgt;
      @(posedge clk);
      @(negedge clk);
      Br_x = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; flush = 1'b0; Br_x = 1'b0; PC_x = '0; taken_x = 1'b0; alu_out = '0;
      PC_f = 32'h100;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      push_exp(1'b0, 1'b0, 32'h104);
      #1;
      obs = {hit_f, pred_taken_f, BrTarget}; e = sb_q.pop_front(); checks++;
      if (obs !== e) begin
         errors++;
         $display("FAIL reset_0x100: got %h expected %h", obs, e);
      end
      PC_f = 32'hFFFF_FFFC;
      push_exp(1'b0, 1'b0, 32'h0);
      #1;
      obs = {hit_f, pred_taken_f, BrTarget}; e = sb_q.pop_front(); checks++;
      if (obs !== e) begin
         errors++;
         $display("FAIL reset_wrap: got %h expected %h", obs, e);
      end
      for (int i = 0; i < 4; i++) begin
         PC_f = $urandom;
         push_exp(1'b0, 1'b0, PC_f + 32'd4);
         #1;
         obs = {hit_f, pred_taken_f, BrTarget}; e = sb_q.pop_front(); checks++;
         if (obs !== e) begin
            errors++;
            $display("FAIL reset_rand_pc %h: got %h expected %h", PC_f, obs, e);
         end
      end
      @(negedge clk);
   endtask

   task automatic test_alloc();
      do_update(32'h100, 1'b1, 32'h200);
      PC_f = 32'h100;
      push_exp(1'b1, 1'b1, 32'h200);
      #1;
      obs = {hit_f, pred_taken_f, BrTarget}; e = sb_q.pop_front(); checks++;
      if (obs !== e) begin
         errors++;
         $display("FAIL alloc_taken: got %h expected %h", obs, e);
      end
   endtask

   task automatic test_counter();
      do_update(32'h100, 1'b0, 32'h0);
      do_update(32'h100, 1'b0, 32'h0);
      PC_f = 32'h100;
      push_exp(1'b1, 1'b0, 32'h104);
      #1;
      obs = {hit_f, pred_taken_f, BrTarget}; e = sb_q.pop_front(); checks++;
      if (obs !== e) begin
         errors++;
         $display("FAIL ctr_floor: got %h expected %h", obs, e);
      end
      do_update(32'h100, 1'b1, 32'h200);
      do_update(32'h100, 1'b1, 32'h200);
      do_update(32'h100, 1'b1, 32'h200);
      do_update(32'h100, 1'b1, 32'h220);
      push_exp(1'b1, 1'b1, 32'h220);
      #1;
      obs = {hit_f, pred_taken_f, BrTarget}; e = sb_q.pop_front(); checks++;
      if (obs !== e) begin
         errors++;
         $display("FAIL ctr_sat_high: got %h expected %h", obs, e);
      end
      // Saturated at 3: one not-taken still predicts taken with the old target.
      do_update(32'h100, 1'b0, 32'hDEAD_0000);
      push_exp(1'b1, 1'b1, 32'h220);
      #1;
      obs = {hit_f, pred_taken_f, BrTarget}; e = sb_q.pop_front(); checks++;
      if (obs !== e) begin
         errors++;
         $display("FAIL ctr_dec_from_sat: got %h expected %h", obs, e);
      end
      do_update(32'h100, 1'b0, 32'h0);
      push_exp(1'b1, 1'b0, 32'h104);
      #1;
      obs = {hit_f, pred_taken_f, BrTarget}; e = sb_q.pop_front(); checks++;
      if (obs !== e) begin
         errors++;
         $display("FAIL ctr_weak_nt: got %h expected %h", obs, e);
      end
   endtask

   task automatic test_alias();
      do_update(32'h140, 1'b1, 32'h300);
      PC_f = 32'h100;
      push_exp(1'b0, 1'b0, 32'h104);
      #1;
      obs = {hit_f, pred_taken_f, BrTarget}; e = sb_q.pop_front(); checks++;
      if (obs !== e) begin
         errors++;
         $display("FAIL alias_evicted: got %h expected %h", obs, e);
      end
      PC_f = 32'h140;
      push_exp(1'b1, 1'b1, 32'h300);
      #1;
      obs = {hit_f, pred_taken_f, BrTarget}; e = sb_q.pop_front(); checks++;
      if (obs !== e) begin
         errors++;
         $display("FAIL alias_new: got %h expected %h", obs, e);
      end
      do_update(32'h180, 1'b0, 32'h500);
      PC_f = 32'h140;
      push_exp(1'b1, 1'b1, 32'h300);
      #1;
      obs = {hit_f, pred_taken_f, BrTarget}; e = sb_q.pop_front(); checks++;
      if (obs !== e) begin
         errors++;
         $display("FAIL nt_miss_kept: got %h expected %h", obs, e);
      end
      PC_f = 32'h180;
      push_exp(1'b0, 1'b0, 32'h184);
      #1;
      obs = {hit_f, pred_taken_f, BrTarget}; e = sb_q.pop_front(); checks++;
      if (obs !== e) begin
         errors++;
         $display("FAIL nt_miss_noalloc: got %h expected %h", obs, e);
      end
   endtask

   task automatic test_flush();
      flush = 1'b1;
      do_update(32'h104, 1'b1, 32'h500);
      flush = 1'b0;
      PC_f = 32'h140;
      push_exp(1'b0, 1'b0, 32'h144);
      #1;
      obs = {hit_f, pred_taken_f, BrTarget}; e = sb_q.pop_front(); checks++;
      if (obs !== e) begin
         errors++;
         $display("FAIL flush_clears: got %h expected %h", obs, e);
      end
      PC_f = 32'h104;
      push_exp(1'b0, 1'b0, 32'h108);
      #1;
      obs = {hit_f, pred_taken_f, BrTarget}; e = sb_q.pop_front(); checks++;
      if (obs !== e) begin
         errors++;
         $display("FAIL flush_drops_update: got %h expected %h", obs, e);
      end
   endtask

   task automatic test_async_reset();
      do_update(32'h100, 1'b1, 32'h200);
      PC_f = 32'h100;
      push_exp(1'b1, 1'b1, 32'h200);
      #1;
      obs = {hit_f, pred_taken_f, BrTarget}; e = sb_q.pop_front(); checks++;
      if (obs !== e) begin
         errors++;
         $display("FAIL pre_reset_hit: got %h expected %h", obs, e);
      end
      rst_n = 1'b0;
      push_exp(1'b0, 1'b0, 32'h104);
      #1;
      obs = {hit_f, pred_taken_f, BrTarget}; e = sb_q.pop_front(); checks++;
      if (obs !== e) begin
         errors++;
         $display("FAIL async_reset: got %h expected %h", obs, e);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      Br_x = 1'b1; PC_x = 32'h100; taken_x = 1'b1; alu_out = 32'h200;
      PC_f = 32'h100;
`ifdef BTB_BYPASS_EN
      push_exp(1'b1, 1'b1, 32'h200);
`else
      push_exp(1'b0, 1'b0, 32'h104);
`endif
      #1;
      obs = {hit_f, pred_taken_f, BrTarget}; e = sb_q.pop_front(); checks++;
      if (obs !== e) begin
         errors++;
         $display("FAIL same_cycle_lookup: got %h expected %h", obs, e);
      end
      @(posedge clk);
      @(negedge clk);
      Br_x = 1'b0;
      push_exp(1'b1, 1'b1, 32'h200);
      #1;
      obs = {hit_f, pred_taken_f, BrTarget}; e = sb_q.pop_front(); checks++;
      if (obs !== e) begin
         errors++;
         $display("FAIL next_cycle_lookup: got %h expected %h", obs, e);
      end
   endtask

   initial begin
      test_reset();
      test_alloc();
      test_counter();
      test_alias();
      test_flush();
      test_async_reset();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
